mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the fetch/execute memory handshake. It samples `memEN`/`RW` and the MAR address, inserts a programmable number of wait states, performs one read or write on an internal word-addressed RAM, and signals completion with `MFC`. `MFC` is held until the initiator drops `memEN`, giving a four-phase handshake. It sits between MAR/MDR and the instruction-fetch and execute controllers, and replaces the hand-driven `MFC` stimulus used in controller benches.

## Interface
Parameters:
- `ADDR_W`, 16, address width (matches the PC/MAR width)
- `DATA_W`, 16, data word width
- `DEPTH`, 256, number of RAM words; must be a power of two, ≤ 2^ADDR_W
- `WAIT_CYCLES`, 2, wait states inserted before the access; 0–15

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-low reset; `rst`=0 at a rising edge resets the block
- `memEN`  in  1  request from the initiator; held high until `MFC` is seen
- `RW`  in  1  1 = read, 0 = write; sampled with `memEN`
- `addr`  in  ADDR_W  word address from MAR
- `wdata`  in  DATA_W  write data from MDR
- `rdata`  out  DATA_W  read data to MDR; registered
- `MFC`  out  1  memory function complete
- `busy`  out  1  high in every state except IDLE

## Operation
States and transitions:
- IDLE: on `memEN`=1, latch `addr`, `RW` and `wdata`.
  - Go to WAIT with counter = `WAIT_CYCLES`.
  - If `WAIT_CYCLES`=0, go straight to ACCESS.
- WAIT: the counter decrements on each edge. When the counter is 1, go to ACCESS. If `memEN` is sampled 0 (abort), go to IDLE with no access and no `MFC`.
- ACCESS: one edge, no abort check.
  - Read: `rdata` <= RAM[latched addr].
  - Write: RAM[latched addr] <= latched wdata; `rdata` is unchanged.
  - Set `MFC`<=1 and go to DONE.
- DONE: hold `MFC`=1 and `rdata` stable. When `memEN` is sampled 0, set `MFC`<=0 and go to IDLE.

Rules:
- Address decode uses `addr[log2(DEPTH)-1:0]`. Upper bits are ignored, so addresses wrap modulo `DEPTH`.
- Changes to `addr`, `RW` or `wdata` after the IDLE capture edge are ignored.
- `memEN`=1 sampled in DONE keeps the block in DONE. A new request is recognised only in IDLE.
- Reset values: state IDLE, `MFC`=0, `rdata`=0, `busy`=0, counter 0. RAM contents are not reset.
- Reset mid-operation: on the reset edge the block returns to IDLE and `MFC` drops. A pending write that has not reached ACCESS is not performed.

## Timing
- Let E0 be the edge at which IDLE samples `memEN`=1.
- `MFC` and valid read `rdata` appear after edge E0+`WAIT_CYCLES`+1.
  - With `WAIT_CYCLES`=2: visible after the 3rd edge following E0.
  - With `WAIT_CYCLES`=0: visible after E0+1.
- `busy` rises after E0 and falls after the same edge that clears `MFC`.
- `MFC` falls on the first edge at which `memEN` is sampled 0 in DONE. A new request can be sampled on the following edge.
- A write is committed at the ACCESS edge. A read issued afterwards returns the new value.

## Structure
- `mem_defs.vh` (shared include) holds:
  - state encodings `S_IDLE`, `S_WAIT`, `S_ACCESS`, `S_DONE`
  - `RW_READ`=1 and `RW_WRITE`=0
  - the default width constants shared with the PC, MAR and MDR
- One sub-module, `mem_array`: a single-port synchronous RAM (`DEPTH`×`DATA_W`) with write enable and a registered read port. It contains no handshake logic.
- `mem_responder` contains the FSM, the wait counter and the request latches.

## Test plan
- Reset: hold `rst`=0 for 2 edges, then release. Required: `MFC`=0, `busy`=0, `rdata`=0.
- Write then read, `WAIT_CYCLES`=2:
  - Write `addr`=0x0010, `wdata`=0xBEEF. Required: `MFC` rises after E0+3, and falls one edge after `memEN` drops.
  - Read 0x0010. Required: `rdata`=0xBEEF when `MFC` rises.
- Wrap-around, `DEPTH`=256: write 0xA5A5 to 0x0105, then read 0x0005. Required: `rdata`=0xA5A5.
- Abort: raise `memEN` for a write of 0x1234 to 0x0020, then drop it after 1 edge in WAIT. Required: `MFC` never rises, `busy` falls, and a later read of 0x0020 returns the old value.
- Held request and reset mid-operation:
  - Keep `memEN`=1 for 5 edges after `MFC` rises. Required: `MFC` stays 1 with no second access.
  - Assert `rst`=0 in DONE. Required: `MFC`=0 and IDLE on the next edge.
- `WAIT_CYCLES`=0 back-to-back reads: two reads of 0x0001 and 0x0002, separated only by the `memEN` low cycle. Required: each `MFC` rises after E0+1 with the correct data.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - shared state encodings, access-direction codes and default widths
package mem_responder_pkg;

    // Default widths shared with the PC, MAR and MDR
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

    // Wait-state counter width; covers WAIT_CYCLES 0..15
    localparam int CNT_W = 4;

    // RW input encoding
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/mem_responder_mem_array.sv
// rtl/mem_responder_mem_array.sv - single-port synchronous RAM with registered read port
module mem_array #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 16,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage write; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    // Read register only updates on a read strobe so data stays stable between reads
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - four-phase memEN/MFC memory responder with programmable wait states
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memEN,
    input  logic              RW,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              MFC,
    output logic              busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [AW-1:0]     addr_q;
    logic              rw_q;
    logic [DATA_W-1:0] wdata_q;
    logic              mfc_q;
    logic              busy_q;
    logic              mem_we;
    logic              mem_re;

    // Upper address bits are ignored so accesses wrap modulo DEPTH
    logic unused_addr;
    assign unused_addr = ^addr;

    // Handshake FSM: request capture, wait countdown with abort, single access, MFC hold
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mfc_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (memEN) begin
                        addr_q  <= addr[AW-1:0];
                        rw_q    <= RW;
                        wdata_q <= wdata;
                        cnt_q   <= CNT_INIT;
                        busy_q  <= 1'b1;
                        state_q <= (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Abort wins over the final countdown step
                    if (!memEN) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                        if (cnt_q == CNT_ONE) begin
                            state_q <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS: begin
                    mfc_q   <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    if (!memEN) begin
                        mfc_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // The RAM sees exactly one strobe, on the ACCESS edge
    assign mem_we = (state_q == S_ACCESS) && (rw_q == RW_WRITE);
    assign mem_re = (state_q == S_ACCESS) && (rw_q == RW_READ);

    mem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_mem_array (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (rdata)
    );

    assign MFC  = mfc_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized self-checking bench for mem_responder (WAIT_CYCLES 2 and 0)
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        men     [2];
    logic        rw      [2];
    logic [15:0] addr_s  [2];
    logic [15:0] wdata_s [2];
    logic [15:0] rdata_s [2];
    logic        mfc     [2];
    logic        busy    [2];

    logic [15:0] model  [2][256];
    logic [15:0] exp_rd [2];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_responder #(.WAIT_CYCLES(2)) dut_w2 (
        .clk(clk), .rst(rst), .memEN(men[0]), .RW(rw[0]), .addr(addr_s[0]),
        .wdata(wdata_s[0]), .rdata(rdata_s[0]), .MFC(mfc[0]), .busy(busy[0])
    );

    mem_responder #(.WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .rst(rst), .memEN(men[1]), .RW(rw[1]), .addr(addr_s[1]),
        .wdata(wdata_s[1]), .rdata(rdata_s[1]), .MFC(mfc[1]), .busy(busy[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // One complete handshake on instance k; optionally holds memEN in DONE and/or resets there
    task automatic request(input int k, input bit is_rd, input logic [15:0] a,
                           input logic [15:0] d, input int hold, input bit rst_in_done);
        int w;
        w = (k == 0) ? 2 : 0;
        @(negedge clk);
        men[k] = 1'b1; rw[k] = is_rd; addr_s[k] = a; wdata_s[k] = d;
        @(posedge clk); #1;
        check("busy_after_e0", busy[k], 1);
        check("mfc_after_e0", mfc[k], 0);
        // request inputs must be ignored once captured
        addr_s[k] = 16'($urandom); wdata_s[k] = 16'($urandom); rw[k] = 1'($urandom);
        if (is_rd) exp_rd[k] = model[k][a[7:0]];
        else model[k][a[7:0]] = d;
        for (int i = 1; i <= w + 1; i++) begin
            @(posedge clk); #1;
            check("mfc_timing", mfc[k], (i == w + 1) ? 1 : 0);
            check("busy_active", busy[k], 1);
        end
        check("rdata_at_mfc", rdata_s[k], exp_rd[k]);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("mfc_held", mfc[k], 1);
            check("rdata_held", rdata_s[k], exp_rd[k]);
        end
        if (rst_in_done) begin
            @(negedge clk); rst = 1'b0;
            @(posedge clk); #1;
            check("mfc_reset_done", mfc[k], 0);
            check("busy_reset_done", busy[k], 0);
            exp_rd[0] = '0; exp_rd[1] = '0;
            check("rdata_reset_done", rdata_s[k], 0);
            @(negedge clk); rst = 1'b1; men[k] = 1'b0;
        end else begin
            @(negedge clk); men[k] = 1'b0;
            @(posedge clk); #1;
            check("mfc_fall", mfc[k], 0);
            check("busy_fall", busy[k], 0);
            check("rdata_after", rdata_s[k], exp_rd[k]);
        end
    endtask

    // Write started on the WAIT_CYCLES=2 instance and withdrawn after one WAIT edge
    task automatic abort_write(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        men[0] = 1'b1; rw[0] = 1'b0; addr_s[0] = a; wdata_s[0] = d;
        @(posedge clk); #1;
        check("abort_busy_e0", busy[0], 1);
        @(posedge clk); #1;
        check("abort_mfc_wait", mfc[0], 0);
        @(negedge clk); men[0] = 1'b0;
        @(posedge clk); #1;
        check("abort_busy_fall", busy[0], 0);
        check("abort_mfc", mfc[0], 0);
        repeat (4) begin
            @(posedge clk); #1;
            check("abort_mfc_quiet", mfc[0], 0);
        end
    endtask

    initial begin
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            men[k] = 1'b0; rw[k] = 1'b1; addr_s[k] = '0; wdata_s[k] = '0; exp_rd[k] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check("reset_mfc", mfc[k], 0);
            check("reset_busy", busy[k], 0);
            check("reset_rdata", rdata_s[k], 0);
        end
        @(negedge clk); rst = 1'b1;

        // give every RAM word a known value so later reads are checkable
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 256; a++)
                request(k, 1'b0, 16'(a), 16'($urandom), 0, 1'b0);

        request(0, 1'b0, 16'h0010, 16'hBEEF, 0, 1'b0);
        request(0, 1'b1, 16'h0010, 16'h0000, 0, 1'b0);
        check("read_beef", rdata_s[0], 16'hBEEF);

        request(0, 1'b0, 16'h0105, 16'hA5A5, 0, 1'b0);
        request(0, 1'b1, 16'h0005, 16'h0000, 0, 1'b0);
        check("wrap_a5a5", rdata_s[0], 16'hA5A5);

        abort_write(16'h0020, 16'h1234);
        request(0, 1'b1, 16'h0020, 16'h0000, 0, 1'b0);

        request(0, 1'b1, 16'h0010, 16'h0000, 5, 1'b1);

        request(1, 1'b1, 16'h0001, 16'h0000, 0, 1'b0);
        request(1, 1'b1, 16'h0002, 16'h0000, 0, 1'b0);
        check("b2b_read2", rdata_s[1], model[1][2]);

        for (int n = 0; n < 200; n++)
            request(int'($urandom_range(1, 0)), 1'($urandom), 16'($urandom), 16'($urandom),
                    int'($urandom_range(3, 0)), 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
